// File: rtl/reg_file_scoreboard_if.sv
// Register file bus: write port, two read ports, scoreboard issue port and
// status outputs. The master side drives requests/addresses; the slave side
// (the register file) drives read data, busy flags and the write counter.
interface reg_file_scoreboard_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int COUNT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]  WRITEDATA;
    logic [ADDR_WIDTH-1:0]  WRITEREG;
    logic                   WRITEENABLE;
    logic [ADDR_WIDTH-1:0]  READREG1;
    logic [ADDR_WIDTH-1:0]  READREG2;
    logic [DATA_WIDTH-1:0]  REGOUT1;
    logic [DATA_WIDTH-1:0]  REGOUT2;
    logic                   BUSYSET;
    logic [ADDR_WIDTH-1:0]  BUSYREG;
    logic                   BUSY1;
    logic                   BUSY2;
    logic [COUNT_WIDTH-1:0] WRITECOUNT;

    modport master (
        output WRITEDATA, WRITEREG, WRITEENABLE, READREG1, READREG2,
               BUSYSET, BUSYREG,
        input  REGOUT1, REGOUT2, BUSY1, BUSY2, WRITECOUNT
    );

    modport slave (
        input  WRITEDATA, WRITEREG, WRITEENABLE, READREG1, READREG2,
               BUSYSET, BUSYREG,
        output REGOUT1, REGOUT2, BUSY1, BUSY2, WRITECOUNT
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Parametrised register file with two combinational read ports, one clocked
// write port, per-register pending-write scoreboard, optional hardwired-zero
// register 0 and a saturating accepted-write counter.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read
// forwarding of data and busy status.
module reg_file_scoreboard #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int ZERO_REG0   = 0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    reg_file_scoreboard_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]       busy;
    logic [DEPTH-1:0]       busy_next;
    logic [COUNT_WIDTH-1:0] count;
    logic                   accept;
    logic                   fwd1;
    logic                   fwd2;

    // A write is accepted unless it targets the hardwired-zero register.
    always_comb begin
        accept = bus.WRITEENABLE && !((ZERO_REG0 != 0) && (bus.WRITEREG == '0));
    end

    // Register storage: async clear, write on accepted requests.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (accept) begin
            regs[bus.WRITEREG] <= bus.WRITEDATA;
        end
    end

    // Next busy vector: completing write clears first, then an issue to the
    // same register sets it again, so a new issue wins over the write.
    always_comb begin
        busy_next = busy;
        if (accept) begin
            busy_next[bus.WRITEREG] = 1'b0;
        end
        if (bus.BUSYSET) begin
            busy_next[bus.BUSYREG] = 1'b1;
        end
        if (ZERO_REG0 != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    // Scoreboard state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Accepted-write counter, holds at all-ones instead of wrapping.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (accept && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write to any read port addressing its target.
    always_comb begin
        fwd1 = accept && !RESET && (bus.READREG1 == bus.WRITEREG);
        fwd2 = accept && !RESET && (bus.READREG2 == bus.WRITEREG);
    end
`else
    // No forwarding: reads see stored state only.
    always_comb begin
        fwd1 = 1'b0;
        fwd2 = 1'b0;
    end
`endif

    // Read port 1 data and busy flag.
    always_comb begin
        if ((ZERO_REG0 != 0) && (bus.READREG1 == '0)) begin
            bus.REGOUT1 = '0;
            bus.BUSY1   = 1'b0;
        end else if (fwd1) begin
            bus.REGOUT1 = bus.WRITEDATA;
            bus.BUSY1   = bus.BUSYSET && (bus.BUSYREG == bus.READREG1);
        end else begin
            bus.REGOUT1 = regs[bus.READREG1];
            bus.BUSY1   = busy[bus.READREG1];
        end
    end

    // Read port 2 data and busy flag.
    always_comb begin
        if ((ZERO_REG0 != 0) && (bus.READREG2 == '0)) begin
            bus.REGOUT2 = '0;
            bus.BUSY2   = 1'b0;
        end else if (fwd2) begin
            bus.REGOUT2 = bus.WRITEDATA;
            bus.BUSY2   = bus.BUSYSET && (bus.BUSYREG == bus.READREG2);
        end else begin
            bus.REGOUT2 = regs[bus.READREG2];
            bus.BUSY2   = busy[bus.READREG2];
        end
    end

    // Counter output.
    always_comb begin
        bus.WRITECOUNT = count;
    end

endmodule
